// File: rtl/muldiv_seq.sv
// Iterative MIPS mult/multu/div/divu sequencer that borrows the shared EX-stage ALU.
// Define MULDIV_SIGNED_EN to enable signed operand handling; otherwise op[0] is ignored.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            div0,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_res
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LastStep = CW'(XLEN - 1);
  localparam logic [3:0] AluAddu = 4'b1001;
  localparam logic [3:0] AluSubu = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX
  } state_e;

  state_e state_q, state_d;

  logic            opDiv_q, opDiv_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            div0_q, div0_d;

`ifdef MULDIV_SIGNED_EN
  logic opSigned_q, opSigned_d;
  logic negRes_q, negRes_d;
  logic negRem_q, negRem_d;
  logic [2*XLEN-1:0] prodRaw;
`else
  logic unusedOpSign;
  assign unusedOpSign = op[0];
`endif

  logic [XLEN-1:0] remShift;
  logic            takeSub;
  logic            mulCarry;
  logic            lastStep;

  assign remShift = {acc_q[XLEN-2:0], q_q[XLEN-1]};
  // The bit shifted out of acc is an implicit 33rd remainder bit, so it forces a subtract.
  assign takeSub  = acc_q[XLEN-1] | (remShift >= b_q);
  assign mulCarry = (alu_res < acc_q);
  assign lastStep = (cnt_q == LastStep);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: state_d = S_ITER;
      S_ITER: if (alu_gnt && lastStep) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    alu_req = busy;
    done    = (state_q == S_FIX);
    div0    = div0_q | (done & opDiv_q & (b_q == '0));
    hi      = hi_q;
    lo      = lo_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = 4'b0000;
    if (state_q == S_ITER) begin
      if (opDiv_q) begin
        alu_a  = remShift;
        alu_b  = b_q;
        alu_op = AluSubu;
      end else begin
        alu_a  = acc_q;
        alu_b  = q_q[0] ? b_q : '0;
        alu_op = AluAddu;
      end
    end
  end

  // Operand latch, magnitude prep, iteration and result fixup.
  always_comb begin
    opDiv_d = opDiv_q;
    acc_d   = acc_q;
    q_d     = q_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;
`ifdef MULDIV_SIGNED_EN
    opSigned_d = opSigned_q;
    negRes_d   = negRes_q;
    negRem_d   = negRem_q;
    prodRaw    = {acc_q, q_q};
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          opDiv_d = op[1];
          q_d     = a;
          b_d     = b;
          div0_d  = 1'b0;
`ifdef MULDIV_SIGNED_EN
          opSigned_d = op[0];
`endif
        end
      end
      S_PREP: begin
        acc_d = '0;
        cnt_d = '0;
`ifdef MULDIV_SIGNED_EN
        q_d      = (opSigned_q && q_q[XLEN-1]) ? -q_q : q_q;
        b_d      = (opSigned_q && b_q[XLEN-1]) ? -b_q : b_q;
        negRes_d = opSigned_q & (q_q[XLEN-1] ^ b_q[XLEN-1]);
        negRem_d = opSigned_q & q_q[XLEN-1];
`endif
      end
      S_ITER: begin
        if (alu_gnt) begin
          cnt_d = cnt_q + 1'b1;
          if (opDiv_q) begin
            acc_d = takeSub ? alu_res : remShift;
            q_d   = {q_q[XLEN-2:0], takeSub};
          end else begin
            acc_d = {mulCarry, alu_res[XLEN-1:1]};
            q_d   = {alu_res[0], q_q[XLEN-1:1]};
          end
        end
      end
      S_FIX: begin
        div0_d = opDiv_q & (b_q == '0);
`ifdef MULDIV_SIGNED_EN
        if (opDiv_q) begin
          lo_d = negRes_q ? -q_q : q_q;
          hi_d = negRem_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = negRes_q ? -prodRaw : prodRaw;
        end
`else
        hi_d = acc_q;
        lo_d = q_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opDiv_q <= 1'b0;
      acc_q   <= '0;
      q_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      opSigned_q <= 1'b0;
      negRes_q   <= 1'b0;
      negRem_q   <= 1'b0;
`endif
    end else begin
      opDiv_q <= opDiv_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
`ifdef MULDIV_SIGNED_EN
      opSigned_q <= opSigned_d;
      negRes_q   <= negRes_d;
      negRem_q   <= negRem_d;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; the bench itself plays the shared ALU.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;
  logic        alu_req;
  logic        alu_gnt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_res;

  int errors = 0;
  int checks = 0;

  int          doneCyc;
  logic        busyPrep;
  logic [3:0]  aluOpPrep;
  logic [3:0]  aluOpIter;
  logic [31:0] aluAIter;
  logic [31:0] aluBIter;
  logic        div0AtDone;

  muldiv_seq #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .div0    (div0),
    .alu_req (alu_req),
    .alu_gnt (alu_gnt),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_res (alu_res)
  );

  always #5 clk = ~clk;

  // Combinational shared ALU: addu / subu, zero otherwise.
  always_comb begin
    alu_res = 32'h0;
    if (alu_op == 4'b1001) alu_res = alu_a + alu_b;
    else if (alu_op == 4'b1010) alu_res = alu_a - alu_b;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and waits (bounded) for done; returns with hi/lo valid.
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                               input int stallFrom, input int stallLen, input bit pulseBusyStart);
    @(negedge clk);
    start = 1'b1; op = opIn; a = aIn; b = bIn; alu_gnt = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'b10; a = 32'h1; b = 32'h1;
    doneCyc = -1;
    div0AtDone = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        busyPrep  = busy;
        aluOpPrep = alu_op;
      end
      if (k == 2) begin
        aluOpIter = alu_op;
        aluAIter  = alu_a;
        aluBIter  = alu_b;
      end
      alu_gnt = !(stallLen > 0 && k >= stallFrom && k < stallFrom + stallLen);
      start   = (pulseBusyStart && k == 5);
      if (done) begin
        doneCyc    = k;
        div0AtDone = div0;
        break;
      end
    end
    start   = 1'b0;
    alu_gnt = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0; alu_gnt = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstAluReq", 64'(alu_req), 64'd0);
    checkOutput("rstHiLo", {hi, lo}, 64'd0);
    checkOutput("rstAluOp", 64'(alu_op), 64'd0);
    rst_n = 1'b1;

    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    checkOutput("multuDoneCyc", 64'(doneCyc), 64'd34);
    checkOutput("multuHiLo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    checkOutput("multuBusyPrep", 64'(busyPrep), 64'd1);
    checkOutput("multuAluOpPrep", 64'(aluOpPrep), 64'h0);
    checkOutput("multuAluOpIter", 64'(aluOpIter), 64'h9);
    checkOutput("multuAluAIter", 64'(aluAIter), 64'h0);
    checkOutput("multuAluBIter", 64'(aluBIter), 64'hFFFF_FFFF);
    checkOutput("multuBusyAfter", 64'(busy), 64'd0);

    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b0);
`ifdef MULDIV_SIGNED_EN
    checkOutput("multNeg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    checkOutput("multNeg", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
`endif

    applyStimulus(2'b10, 32'd100, 32'd7, 0, 0, 1'b0);
    checkOutput("divuHiLo", {hi, lo}, {32'd2, 32'd14});
    checkOutput("divuAluOpIter", 64'(aluOpIter), 64'hA);
    checkOutput("divuDiv0", 64'(div0), 64'd0);

    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
`ifdef MULDIV_SIGNED_EN
    checkOutput("divNeg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    checkOutput("divNeg", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
`endif

    applyStimulus(2'b10, 32'd5, 32'd0, 0, 0, 1'b0);
    checkOutput("div0HiLo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    checkOutput("div0AtDone", 64'(div0AtDone), 64'd1);
    checkOutput("div0Held", 64'(div0), 64'd1);

    applyStimulus(2'b00, 32'd12345, 32'd678, 10, 3, 1'b1);
    checkOutput("stallDoneCyc", 64'(doneCyc), 64'd37);
    checkOutput("stallHiLo", {hi, lo}, 64'd8369910);
    checkOutput("div0Cleared", 64'(div0), 64'd0);

    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
`ifdef MULDIV_SIGNED_EN
    checkOutput("divMinByNeg1", {hi, lo}, 64'h0000_0000_8000_0000);
`else
    checkOutput("divMinByNeg1", {hi, lo}, 64'h8000_0000_0000_0000);
`endif

    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd999; b = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("preRstBusy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstDoneDiv0", {62'd0, done, div0}, 64'd0);
    checkOutput("midRstAluReq", 64'(alu_req), 64'd0);
    checkOutput("midRstHiLo", {hi, lo}, 64'd0);
    checkOutput("midRstAluAB", {alu_a, alu_b}, 64'd0);
    checkOutput("midRstAluOp", 64'(alu_op), 64'd0);
    rst_n = 1'b1;

    applyStimulus(2'b10, 32'd1000, 32'd7, 0, 0, 1'b0);
    checkOutput("postRstDoneCyc", 64'(doneCyc), 64'd34);
    checkOutput("postRstHiLo", {hi, lo}, {32'd6, 32'd142});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
